// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO master.
// Holds the FSM state type, frame field codes, field lengths and the header builder.
package mdio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_HDR,
      ST_TA,
      ST_DATA,
      ST_END
   } mdio_state_t;

   localparam logic [1:0] MDIO_OP_RD = 2'b10;
   localparam logic [1:0] MDIO_OP_WR = 2'b01;
   localparam logic [1:0] MDIO_ST    = 2'b01;

   localparam int unsigned MDIO_HDR_LEN  = 14;
   localparam int unsigned MDIO_TA_LEN   = 2;
   localparam int unsigned MDIO_DATA_LEN = 16;

   // ST, OP, PHYAD, REGAD in transmit order, MSB first.
   function automatic logic [13:0] mdio_hdr(input logic       rd,
                                            input logic [4:0] phy,
                                            input logic [4:0] regad);
      return {MDIO_ST, (rd ? MDIO_OP_RD : MDIO_OP_WR), phy, regad};
   endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC divider: CLK_DIV mclk cycles low then CLK_DIV high per bit, restarting at phase 0 on enable.
// rise_stb/fall_stb flag the mclk cycle whose closing edge moves MDC high/low.
module mdio_clkgen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic mclk,
   input  logic reset_n,
   input  logic en,
   output logic mdio_clk,
   output logic fall_stb,
   output logic rise_stb
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] div_cnt;
   logic       half_done;

   assign half_done = en && (div_cnt == DIV_LAST);
   assign rise_stb  = half_done && !mdio_clk;
   assign fall_stb  = half_done && mdio_clk;

   always_ff @(posedge mclk) begin
      if (!reset_n || !en) begin
         div_cnt  <= 8'd0;
         mdio_clk <= 1'b0;
      end else if (half_done) begin
         div_cnt  <= 8'd0;
         mdio_clk <= ~mdio_clk;
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises read/write frames from a valid/ready command port.
// Build macro MDIO_PREAMBLE_SUPPRESS_EN adds cfg_pre_sup to skip the preamble per command.
//
// state | meaning
// IDLE  | ready for a command, MDC held low
// PRE   | PRE_LEN preamble ones, driven
// HDR   | ST, OP, PHYAD, REGAD, driven MSB first
// TA    | turnaround: write drives 1,0; read releases the line
// DATA  | 16 data bits: write drives, read samples on MDC rise
// END   | one released MDC period, then the response strobe
module mdio_master
   import mdio_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned PRE_LEN = 32
) (
   input  logic        mclk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_read,
   input  logic [4:0]  cmd_phy_addr,
   input  logic [4:0]  cmd_reg_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_ta_err,
   output logic        mdio_clk,
   output logic        mdio_out,
   output logic        mdio_oeb,
   input  logic        mdio_in
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   ,
   input  logic        cfg_pre_sup
`endif
);

   localparam logic [5:0] PRE_LAST  = 6'(PRE_LEN - 1);
   localparam logic [5:0] HDR_LAST  = 6'(MDIO_HDR_LEN - 1);
   localparam logic [5:0] TA_LAST   = 6'(MDIO_TA_LEN - 1);
   localparam logic [5:0] DATA_LAST = 6'(MDIO_DATA_LEN - 1);

   mdio_state_t state;
   logic [5:0]  bit_cnt;
   logic        clk_en;
   logic [15:0] tx_sh;
   logic [15:0] rx_sh;
   logic [15:0] wdata_q;
   logic        rd_q;
   logic        ta_bad;
   logic        fall_stb;
   logic        rise_stb;
   logic        pre_sup;
   logic [13:0] hdr_word;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   assign pre_sup = cfg_pre_sup;
`else
   assign pre_sup = 1'b0;
`endif

   assign hdr_word = mdio_hdr(cmd_read, cmd_phy_addr, cmd_reg_addr);

   mdio_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .mclk     (mclk),
      .reset_n  (reset_n),
      .en       (clk_en),
      .mdio_clk (mdio_clk),
      .fall_stb (fall_stb),
      .rise_stb (rise_stb)
   );

   always_ff @(posedge mclk) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         bit_cnt    <= 6'd0;
         clk_en     <= 1'b0;
         tx_sh      <= 16'd0;
         rx_sh      <= 16'd0;
         wdata_q    <= 16'd0;
         rd_q       <= 1'b0;
         ta_bad     <= 1'b0;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 16'd0;
         rsp_ta_err <= 1'b0;
         mdio_out   <= 1'b1;
         mdio_oeb   <= 1'b1;
      end else begin
         rsp_valid <= 1'b0;

         // Slave data is sampled on the edge that raises MDC.
         if (rise_stb && rd_q) begin
            if (state == ST_TA && bit_cnt == 6'd0) begin
               ta_bad <= mdio_in;
            end
            if (state == ST_DATA) begin
               rx_sh <= {rx_sh[14:0], mdio_in};
            end
         end

         case (state)
            ST_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  clk_en    <= 1'b1;
                  rd_q      <= cmd_read;
                  wdata_q   <= cmd_wdata;
                  ta_bad    <= 1'b0;
                  rx_sh     <= 16'd0;
                  mdio_oeb  <= 1'b0;
                  tx_sh     <= {hdr_word, 2'b00};
                  if (pre_sup) begin
                     state    <= ST_HDR;
                     bit_cnt  <= HDR_LAST;
                     mdio_out <= hdr_word[13];
                     tx_sh    <= {hdr_word[12:0], 3'b000};
                  end else begin
                     state    <= ST_PRE;
                     bit_cnt  <= PRE_LAST;
                     mdio_out <= 1'b1;
                  end
               end
            end

            default: begin
               if (fall_stb) begin
                  if (bit_cnt != 6'd0) begin
                     bit_cnt <= bit_cnt - 6'd1;
                     if (state == ST_HDR ||
                         (!rd_q && (state == ST_TA || state == ST_DATA))) begin
                        mdio_out <= tx_sh[15];
                        tx_sh    <= {tx_sh[14:0], 1'b0};
                     end
                  end else begin
                     case (state)
                        ST_PRE: begin
                           state    <= ST_HDR;
                           bit_cnt  <= HDR_LAST;
                           mdio_out <= tx_sh[15];
                           tx_sh    <= {tx_sh[14:0], 1'b0};
                        end
                        ST_HDR: begin
                           state    <= ST_TA;
                           bit_cnt  <= TA_LAST;
                           mdio_out <= 1'b1;
                           tx_sh    <= 16'd0;
                           mdio_oeb <= rd_q;
                        end
                        ST_TA: begin
                           state   <= ST_DATA;
                           bit_cnt <= DATA_LAST;
                           if (!rd_q) begin
                              mdio_out <= wdata_q[15];
                              tx_sh    <= {wdata_q[14:0], 1'b0};
                           end
                        end
                        ST_DATA: begin
                           state    <= ST_END;
                           bit_cnt  <= 6'd0;
                           mdio_out <= 1'b1;
                           mdio_oeb <= 1'b1;
                        end
                        ST_END: begin
                           // cmd_ready stays low this cycle so a held cmd_valid lands one cycle later.
                           state      <= ST_IDLE;
                           clk_en     <= 1'b0;
                           rsp_valid  <= 1'b1;
                           rsp_rdata  <= rd_q ? rx_sh : 16'd0;
                           rsp_ta_err <= rd_q && ta_bad;
                        end
                        default: begin
                           state    <= ST_IDLE;
                           clk_en   <= 1'b0;
                           mdio_out <= 1'b1;
                           mdio_oeb <= 1'b1;
                        end
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_master.sv
// Randomised scoreboard bench for mdio_master with a slave model and a frame-level reference model.
// Expected bitstreams and responses are built from the frame format when each handshake is seen.
`timescale 1ns/1ps
module tb_mdio_master;

   localparam int CLK_DIV = 4;
   localparam int PRE_LEN = 32;

   logic        mclk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_read = 1'b0;
   logic [4:0]  cmd_phy_addr = 5'd0;
   logic [4:0]  cmd_reg_addr = 5'd0;
   logic [15:0] cmd_wdata = 16'd0;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_ta_err;
   logic        mdio_clk;
   logic        mdio_out;
   logic        mdio_oeb;
   logic        mdio_in = 1'b1;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   logic        cfg_pre_sup = 1'b0;
`endif

   always #5 mclk = ~mclk;

   mdio_master #(.CLK_DIV(CLK_DIV), .PRE_LEN(PRE_LEN)) dut (
      .mclk         (mclk),
      .reset_n      (reset_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_read     (cmd_read),
      .cmd_phy_addr (cmd_phy_addr),
      .cmd_reg_addr (cmd_reg_addr),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_ta_err   (rsp_ta_err),
      .mdio_clk     (mdio_clk),
      .mdio_out     (mdio_out),
      .mdio_oeb     (mdio_oeb),
      .mdio_in      (mdio_in)
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      ,
      .cfg_pre_sup  (cfg_pre_sup)
`endif
   );

   typedef struct {
      bit        rd;
      bit [4:0]  phy;
      bit [4:0]  rega;
      bit [15:0] wd;
      bit        slave;
      bit        ta_bad;
      bit [15:0] sd;
      bit        pre_sup;
      bit        b2b;
   } cmd_t;

   typedef struct {
      bit [15:0] rdata;
      bit        ta_err;
      int        len;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;

   cmd_t fr;
   bit   exp_val [0:64];
   bit   exp_oeb [0:64];
   int   fr_len = 0;
   bit   frame_on = 0;
   bit   hs_pend = 0;
   int   rise_cnt = 0;
   int   hi_len = 0;
   bit   prev_clk = 0;
   int   last_rsp_cyc = -100;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void flag(string name, int a, int b);
      n_vec++;
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, a, b, cyc);
   endfunction

   // Reference frame: preamble ones, ST, OP, PHYAD, REGAD, TA, data, idle END period.
   function automatic void build_expect(cmd_t c);
      logic [13:0] hdr;
      int n;
      n = 0;
      hdr = {2'b01, (c.rd ? 2'b10 : 2'b01), c.phy, c.rega};
      if (!c.pre_sup) begin
         for (int i = 0; i < PRE_LEN; i++) begin
            exp_val[n] = 1'b1; exp_oeb[n] = 1'b0; n++;
         end
      end
      for (int i = 13; i >= 0; i--) begin
         exp_val[n] = hdr[i]; exp_oeb[n] = 1'b0; n++;
      end
      for (int i = 0; i < 2; i++) begin
         exp_val[n] = (i == 0); exp_oeb[n] = c.rd; n++;
      end
      for (int i = 15; i >= 0; i--) begin
         exp_val[n] = c.wd[i]; exp_oeb[n] = c.rd; n++;
      end
      exp_val[n] = 1'b1; exp_oeb[n] = 1'b1; n++;
      fr_len = n;
   endfunction

   function automatic rsp_t expect_rsp(cmd_t c);
      rsp_t r;
      r.len = (c.pre_sup ? 0 : PRE_LEN) + 33;
      if (!c.rd) begin
         r.rdata = 16'd0; r.ta_err = 1'b0;
      end else if (!c.slave) begin
         r.rdata = 16'hFFFF; r.ta_err = 1'b1;
      end else begin
         r.rdata = c.sd; r.ta_err = c.ta_bad;
      end
      return r;
   endfunction

   // What the slave (or the pull-up) puts on the line during frame bit idx.
   function automatic bit slave_bit(cmd_t c, int idx);
      int p;
      p = c.pre_sup ? 0 : PRE_LEN;
      if (!c.rd || !c.slave) return 1'b1;
      if (idx == p + 15) return c.ta_bad;
      if (idx >= p + 16 && idx < p + 32) return c.sd[p + 31 - idx];
      return 1'b1;
   endfunction

   // Monitor / scoreboard, sampling on the falling mclk edge.
   always @(negedge mclk) begin
      rsp_t r;
      cyc++;
      if (!reset_n) begin
         frame_on = 0; hs_pend = 0; rsp_q.delete();
         mdio_in = 1'b1; prev_clk = 0; hi_len = 0; rise_cnt = 0;
      end else begin
         if (hs_pend) begin
            hs_pend = 0; frame_on = 1; rise_cnt = 0;
            chk("first_bit_oeb", mdio_oeb, 0);
            chk("first_bit_val", mdio_out, exp_val[0]);
            chk("first_bit_mdc", mdio_clk, 0);
            chk("busy_ready", cmd_ready, 0);
            mdio_in = slave_bit(fr, 0);
         end
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               flag("unexpected_rsp", 1, 0);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, r.rdata);
               chk("rsp_ta_err", rsp_ta_err, r.ta_err);
               chk("frame_len", rise_cnt, r.len);
            end
            last_rsp_cyc = cyc;
            frame_on = 0;
            mdio_in = 1'b1;
         end
         if (mdio_clk) hi_len++;
         if (mdio_clk && !prev_clk) begin
            if (!frame_on || rise_cnt >= fr_len) begin
               flag("stray_mdc", rise_cnt, fr_len);
            end else begin
               chk("bit_oeb", mdio_oeb, exp_oeb[rise_cnt]);
               if (!exp_oeb[rise_cnt]) chk("bit_val", mdio_out, exp_val[rise_cnt]);
            end
            rise_cnt++;
            if (frame_on) mdio_in = slave_bit(fr, rise_cnt);
         end
         if (!mdio_clk && prev_clk) begin
            chk("mdc_high_len", hi_len, CLK_DIV);
            hi_len = 0;
         end
         prev_clk = mdio_clk;
         if (cmd_valid && cmd_ready) begin
            if (cmd_q.size() == 0) begin
               flag("handshake_without_cmd", 1, 0);
            end else begin
               fr = cmd_q.pop_front();
               build_expect(fr);
               rsp_q.push_back(expect_rsp(fr));
               if (fr.b2b) chk("b2b_gap", cyc - last_rsp_cyc, 1);
               hs_pend = 1;
            end
         end
      end
   end

   function automatic cmd_t rand_cmd();
      cmd_t c;
      c.rd      = 1'($urandom_range(0, 1));
      c.phy     = 5'($urandom);
      c.rega    = 5'($urandom);
      c.wd      = 16'($urandom);
      c.slave   = ($urandom_range(0, 3) != 0);
      c.ta_bad  = ($urandom_range(0, 4) == 0);
      c.sd      = 16'($urandom);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      c.pre_sup = 1'($urandom_range(0, 1));
`else
      c.pre_sup = 1'b0;
`endif
      c.b2b     = 1'b0;
      return c;
   endfunction

   // Drive a command from posedge+1 and return just after its handshake edge.
   task automatic issue(input cmd_t c, input bit keep);
      bit got;
      cmd_read = c.rd; cmd_phy_addr = c.phy; cmd_reg_addr = c.rega; cmd_wdata = c.wd;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      cfg_pre_sup = c.pre_sup;
`endif
      cmd_valid = 1'b1;
      cmd_q.push_back(c);
      got = 0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge mclk);
         if (cmd_ready) begin got = 1; break; end
      end
      if (!got) begin
         flag("handshake_timeout", 0, 1);
         cmd_q.delete();
         cmd_valid = 1'b0;
      end
      @(posedge mclk); #1;
      if (!keep) cmd_valid = 1'b0;
      // Inputs wander while busy; the latched copy must be used.
      cmd_read = 1'($urandom); cmd_phy_addr = 5'($urandom);
      cmd_reg_addr = 5'($urandom); cmd_wdata = 16'($urandom);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      cfg_pre_sup = 1'($urandom);
`endif
   endtask

   task automatic wait_idle();
      bit done;
      done = 0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge mclk);
         if (cmd_q.size() == 0 && rsp_q.size() == 0 && !frame_on && !hs_pend) begin
            done = 1; break;
         end
      end
      if (!done) flag("idle_timeout", 0, 1);
      @(posedge mclk); #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_t c;
      bit keep, keep_prev;
      bit got;

      repeat (3) @(posedge mclk);
      @(negedge mclk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_ta_err", rsp_ta_err, 0);
      chk("rst_mdio_clk", mdio_clk, 0);
      chk("rst_mdio_out", mdio_out, 1);
      chk("rst_mdio_oeb", mdio_oeb, 1);
      @(posedge mclk); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge mclk); #1;

      c = rand_cmd();
      c.rd = 0; c.phy = 5'h01; c.rega = 5'h04; c.wd = 16'hA5C3; c.pre_sup = 0;
      issue(c, 0); wait_idle();

      c = rand_cmd();
      c.rd = 1; c.phy = 5'h1F; c.rega = 5'h02; c.slave = 1; c.ta_bad = 0;
      c.sd = 16'h0141; c.pre_sup = 0;
      issue(c, 0); wait_idle();

      c = rand_cmd();
      c.rd = 1; c.slave = 0; c.pre_sup = 0;
      issue(c, 0); wait_idle();

      c = rand_cmd(); c.rd = 0;
      issue(c, 1);
      c = rand_cmd(); c.rd = 1; c.slave = 1; c.b2b = 1;
      issue(c, 0); wait_idle();

      // Reset pulse in the middle of DATA: no response may follow.
      c = rand_cmd(); c.rd = 0; c.pre_sup = 0;
      issue(c, 0);
      got = 0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge mclk);
         if (rise_cnt >= 52) begin got = 1; break; end
      end
      if (!got) flag("reach_data_timeout", rise_cnt, 52);
      @(posedge mclk); #1; reset_n = 1'b0;
      @(posedge mclk); #1; reset_n = 1'b1;
      @(negedge mclk);
      chk("midrst_mdio_clk", mdio_clk, 0);
      chk("midrst_mdio_oeb", mdio_oeb, 1);
      chk("midrst_cmd_ready", cmd_ready, 1);
      chk("midrst_rsp_valid", rsp_valid, 0);
      cmd_q.delete();
      repeat (700) @(posedge mclk);
      #1;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      c = rand_cmd(); c.rd = 0; c.pre_sup = 1;
      issue(c, 0); wait_idle();
`endif

      keep_prev = 0;
      for (int t = 0; t < 14; t++) begin
         c = rand_cmd();
         c.b2b = keep_prev;
         keep = (t != 13) && ($urandom_range(0, 2) == 0);
         issue(c, keep);
         keep_prev = keep;
         if (!keep) begin
            wait_idle();
            repeat ($urandom_range(0, 5)) @(posedge mclk);
            #1;
         end
      end
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
